uart_io: RTL and testbench
==========================

// Module: uart_io
// PURPOSE
//  Serial front end for the CPU core's UART port. Deserialises rxd into an RX FIFO
//  that the core pops through uart_empty/uart_in/uart_rdreq. Buffers core writes
//  (uart_out/uart_wrreq) in a TX FIFO and serialises them onto txd.
//  Format: 8N1, LSB first, idle high. Sits between the board pins and the core.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  BAUD        115_200     line rate; BIT_CYC = (CLK_HZ + BAUD/2) / BAUD clocks per bit
//  FIFO_DEPTH  16          entries per FIFO; power of 2, >= 2
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  rxd          in   1  serial input, asynchronous to clk
//  txd          out  1  serial output
//  uart_empty   out  1  RX FIFO empty
//  uart_in      out  8  RX FIFO head byte (show-ahead); valid when uart_empty=0
//  uart_rdreq   in   1  pop RX head this cycle
//  uart_out     in   8  byte to transmit
//  uart_wrreq   in   1  push uart_out into TX FIFO this cycle
//  rx_overrun   out  1  sticky: received byte dropped because RX FIFO was full
//  frame_err    out  1  sticky: stop bit sampled low
//  tx_overflow  out  1  sticky: uart_wrreq seen while TX FIFO was full
//  err_clr      in   1  synchronous clear of the three sticky flags
// BEHAVIOUR
//  Reset values:
//   - txd=1, uart_empty=1, uart_in=0, all sticky flags 0
//   - both FIFOs empty; both FSMs IDLE; counters 0
//  rxd path: 2-flop synchroniser; every RX decision uses the second flop.
//  RX FSM, bit counter cnt counting 0..BIT_CYC-1:
//   - IDLE: synced rxd=0 -> START, cnt=0
//   - START: at cnt=BIT_CYC/2, rxd=1 -> IDLE (glitch, nothing pushed);
//     rxd=0 -> DATA, cnt=0
//   - DATA: sample at each cnt=BIT_CYC-1, i.e. mid-bit; shift in LSB first.
//     After the 8th sample -> STOP
//   - STOP: sample at cnt=BIT_CYC-1.
//     rxd=1 -> push the byte; if RX FIFO is full, drop it and set rx_overrun.
//     rxd=0 -> drop the byte, set frame_err.
//     Both cases -> IDLE; IDLE re-arms on the next falling edge.
//  RX FIFO read side:
//   - show-ahead: uart_in updates in the cycle after a push into an empty FIFO
//     or after a pop; uart_empty falls in that same cycle
//   - uart_rdreq while empty: ignored, no pointer change
//   - push and pop in the same cycle when not full: both take effect, count unchanged
//   - full and pop in the same cycle as the RX STOP push: push accepted, no overrun
//  TX FIFO: uart_wrreq pushes uart_out.
//   - if full and no pop this cycle: write dropped, tx_overflow set
//   - pointers wrap modulo FIFO_DEPTH; count is held in log2(FIFO_DEPTH)+1 bits
//  TX FSM:
//   - IDLE: txd=1; FIFO not empty -> pop head into shift reg, -> START
//   - START: txd=0 for BIT_CYC clocks -> DATA
//   - DATA: 8 bits, LSB first, BIT_CYC clocks each -> STOP
//   - STOP: txd=1 for BIT_CYC clocks -> IDLE
//   - a back-to-back byte starts START in the cycle after STOP ends, with no extra idle
//   - txd is driven from a register (glitch-free)
//  Latency: a byte pushed into an empty TX FIFO in cycle N gives txd=0 in cycle N+2.
//  Sticky flags: set and err_clr in the same cycle -> set wins.
//  Reset mid-frame: asserting rst_n=0 aborts immediately. txd returns to 1, FIFO
//  contents are lost, and the partial RX byte is discarded.
// TESTING (CLK_HZ=1_000_000, BAUD=100_000 -> BIT_CYC=10, FIFO_DEPTH=4)
//  - drive 0xA5 on rxd at 10 clk/bit -> uart_empty falls after the stop bit,
//    uart_in=0xA5; one rdreq -> uart_empty=1
//  - core writes 0x3C once -> txd shows 0,0,0,1,1,1,1,0,0,1, each held 10 clks,
//    then idles high
//  - 3-clk low pulse on idle rxd -> nothing pushed; frame_err stays 0
//  - byte 0x55 with stop bit forced low -> no push; frame_err=1;
//    err_clr -> frame_err=0
//  - 5 bytes received with no rdreq -> 4 stored (first 4, in order); rx_overrun=1
//  - 6 wrreq in consecutive cycles while TX idle -> 5 bytes sent in order,
//    back-to-back; tx_overflow=1
//  - rst_n pulsed low mid-TX-frame -> txd=1 at once; FIFOs empty; no further output

Source files
------------

// File: rtl/uart_io.sv
// 8N1 UART front end: synchronised receiver into a show-ahead RX FIFO,
// TX FIFO drained by a registered-output serialiser.
module uart_io #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       txd,
  output logic       uart_empty,
  output logic [7:0] uart_in,
  input  logic       uart_rdreq,
  input  logic [7:0] uart_out,
  input  logic       uart_wrreq,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       tx_overflow,
  input  logic       err_clr
);

  localparam int unsigned BIT_CYC = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW      = $clog2(BIT_CYC + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LVLW    = AW + 1;

  localparam logic [CW-1:0]   CNT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(BIT_CYC / 2);
  localparam logic [LVLW-1:0] LVL_FULL = LVLW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic            rx_s1_q, rx_s2_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_push, ferr_set;

  logic [7:0]      rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LVLW-1:0] rx_lvl_q, rx_lvl_d, rx_rem;
  logic            rx_pop, rx_wr, rx_full, ovr_set;
  logic            uart_empty_q, uart_empty_d;
  logic [7:0]      uart_in_q, uart_in_d;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic            txd_q, txd_d;
  logic            tx_pop, tx_wr, tx_full, ovf_set;

  logic [7:0]      tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [LVLW-1:0] tx_lvl_q, tx_lvl_d;

  logic            rx_overrun_q, rx_overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            tx_overflow_q, tx_overflow_d;

  // RX framing: start validated at half bit, data/stop sampled one bit later each
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_push    = rx_s2_q;
          ferr_set   = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX FIFO; a pop frees the slot for a same-cycle push even when full
  always_comb begin
    rx_full   = (rx_lvl_q == LVL_FULL);
    rx_pop    = uart_rdreq && (rx_lvl_q != '0);
    rx_wr     = rx_push && (!rx_full || rx_pop);
    ovr_set   = rx_push && rx_full && !rx_pop;
    rx_wptr_d = rx_wptr_q + AW'(rx_wr);
    rx_rptr_d = rx_rptr_q + AW'(rx_pop);
    rx_lvl_d  = rx_lvl_q + LVLW'(rx_wr) - LVLW'(rx_pop);
    rx_rem    = rx_lvl_q - LVLW'(rx_pop);
    uart_empty_d = (rx_lvl_d == '0);
    uart_in_d    = uart_in_q;
    if (rx_rem == '0) begin
      if (rx_wr) uart_in_d = rx_sh_q;
    end else begin
      uart_in_d = rx_mem_q[rx_rptr_d];
    end
  end

  // TX serialiser; txd_d is set on the transition so each level lasts BIT_CYC clocks
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (tx_lvl_q != '0) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem_q[tx_rptr_q];
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          txd_d      = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_lvl_q != '0) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_mem_q[tx_rptr_q];
            tx_state_d = TX_START;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            txd_d      = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_full   = (tx_lvl_q == LVL_FULL);
    tx_wr     = uart_wrreq && (!tx_full || tx_pop);
    ovf_set   = uart_wrreq && tx_full && !tx_pop;
    tx_wptr_d = tx_wptr_q + AW'(tx_wr);
    tx_rptr_d = tx_rptr_q + AW'(tx_pop);
    tx_lvl_d  = tx_lvl_q + LVLW'(tx_wr) - LVLW'(tx_pop);
  end

  // Sticky flags: a set in the clearing cycle wins
  always_comb begin
    rx_overrun_d  = ovr_set  || (rx_overrun_q  && !err_clr);
    frame_err_d   = ferr_set || (frame_err_q   && !err_clr);
    tx_overflow_d = ovf_set  || (tx_overflow_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wptr_q] <= rx_sh_q;
    if (tx_wr) tx_mem_q[tx_wptr_q] <= uart_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_sh_q       <= '0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_lvl_q      <= '0;
      uart_empty_q  <= 1'b1;
      uart_in_q     <= '0;
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_sh_q       <= '0;
      txd_q         <= 1'b1;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_lvl_q      <= '0;
      rx_overrun_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rx_s1_q       <= rxd;
      rx_s2_q       <= rx_s1_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_sh_q       <= rx_sh_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      rx_lvl_q      <= rx_lvl_d;
      uart_empty_q  <= uart_empty_d;
      uart_in_q     <= uart_in_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_sh_q       <= tx_sh_d;
      txd_q         <= txd_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      tx_lvl_q      <= tx_lvl_d;
      rx_overrun_q  <= rx_overrun_d;
      frame_err_q   <= frame_err_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  assign txd         = txd_q;
  assign uart_empty  = uart_empty_q;
  assign uart_in     = uart_in_q;
  assign rx_overrun  = rx_overrun_q;
  assign frame_err   = frame_err_q;
  assign tx_overflow = tx_overflow_q;

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io at 10 clocks/bit, 4-entry FIFOs, with RX/TX scoreboards.
module tb_uart_io;

  localparam int unsigned BIT_CYC = 10;
  localparam int unsigned DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n, rxd, uart_rdreq, uart_wrreq, err_clr;
  logic [7:0] uart_out;
  logic       txd, uart_empty, rx_overrun, frame_err, tx_overflow;
  logic [7:0] uart_in;

  uart_io #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd),
    .uart_empty(uart_empty), .uart_in(uart_in), .uart_rdreq(uart_rdreq),
    .uart_out(uart_out), .uart_wrreq(uart_wrreq),
    .rx_overrun(rx_overrun), .frame_err(frame_err), .tx_overflow(tx_overflow),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] rx_exp_q [$];
  logic [7:0] tx_exp_q [$];
  int         tx_start_q [$];
  logic       exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Frame decoder on txd, sampling mid-bit; aborted by reset
  bit         mon_busy = 1'b0;
  int         mon_pos = 0;
  logic [7:0] mon_byte = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_pos  = 0;
        tx_start_q.push_back(cyc);
      end
    end else begin
      mon_pos++;
      if (mon_pos == 5) begin
        check("tx_start_bit", 32'(txd), 32'd0);
      end else if (mon_pos >= 15 && mon_pos <= 85 && (mon_pos % 10) == 5) begin
        mon_byte = {txd, mon_byte[7:1]};
      end else if (mon_pos == 95) begin
        check("tx_stop_bit", 32'(txd), 32'd1);
        check("tx_byte_expected", 32'(tx_exp_q.size() != 0), 32'd1);
        if (tx_exp_q.size() != 0) check("tx_byte", 32'(mon_byte), 32'(tx_exp_q.pop_front()));
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
    rxd = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT_CYC) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic pop_rx(input string tag);
    int t = 0;
    while (uart_empty !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ready"}, 32'(uart_empty), 32'd0);
    if (rx_exp_q.size() != 0) check(tag, 32'(uart_in), 32'(rx_exp_q.pop_front()));
    uart_rdreq = 1'b1;
    @(negedge clk);
    uart_rdreq = 1'b0;
  endtask

  task automatic wait_tx_done(input string tag);
    int t = 0;
    while ((tx_exp_q.size() != 0 || mon_busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(tx_exp_q.size()), 32'd0);
  endtask

  initial begin
    int lows;
    rst_n = 1'b0; rxd = 1'b1; uart_rdreq = 1'b0; uart_wrreq = 1'b0;
    err_clr = 1'b0; uart_out = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_empty", 32'(uart_empty), 32'd1);
    check("rst_uart_in", 32'(uart_in), 32'd0);
    check("rst_flags", 32'({rx_overrun, frame_err, tx_overflow}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte receive and pop
    send_rx(8'hA5, 1'b1);
    pop_rx("rx_a5");
    check("rx_empty_after_pop", 32'(uart_empty), 32'd1);

    // Pop while empty must not move pointers
    uart_rdreq = 1'b1;
    repeat (3) @(negedge clk);
    uart_rdreq = 1'b0;
    send_rx(8'h5A, 1'b1);
    pop_rx("rx_5a_after_empty_pop");
    check("rx_empty_after_5a", 32'(uart_empty), 32'd1);

    // Single TX byte with push-to-start latency
    uart_out = 8'h3C;
    uart_wrreq = 1'b1;
    tx_exp_q.push_back(8'h3C);
    @(negedge clk);
    uart_wrreq = 1'b0;
    check("tx_lat_n1", 32'(txd), 32'd1);
    @(negedge clk);
    check("tx_lat_n2", 32'(txd), 32'd0);
    wait_tx_done("tx_3c_done");
    repeat (20) @(negedge clk);
    check("tx_idle_high", 32'(txd), 32'd1);

    // Start glitch is rejected
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_push", 32'(uart_empty), 32'd1);
    check("glitch_no_ferr", 32'(frame_err), 32'd0);

    // Framing error
    send_rx(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    check("ferr_no_push", 32'(uart_empty), 32'd1);
    check("ferr_set", 32'(frame_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ferr_clr", 32'(frame_err), 32'd0);

    // Five bytes into a four-deep FIFO
    exp_ovr = 1'b0;
    for (int i = 0; i < 5; i++) send_rx(8'h11 * 8'(i + 1), 1'b1);
    check("rx_overrun", 32'(rx_overrun), 32'(exp_ovr));
    check("rx_overrun_expected", 32'(exp_ovr), 32'd1);
    for (int i = 0; i < 4; i++) pop_rx("rx_fill");
    check("rx_empty_after_fill", 32'(uart_empty), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_clr", 32'(rx_overrun), 32'd0);

    // Six back-to-back writes: first pops straight into the serialiser, four fill, sixth drops
    tx_start_q.delete();
    for (int i = 0; i < 6; i++) begin
      uart_out = 8'hC0 + 8'(i);
      uart_wrreq = 1'b1;
      if (i < 5) tx_exp_q.push_back(uart_out);
      @(negedge clk);
    end
    uart_wrreq = 1'b0;
    check("tx_overflow", 32'(tx_overflow), 32'd1);
    wait_tx_done("tx_burst_done");
    check("tx_burst_frames", 32'(tx_start_q.size()), 32'd5);
    for (int i = 1; i < tx_start_q.size(); i++)
      check("tx_back_to_back", 32'(tx_start_q[i] - tx_start_q[i-1]), 32'(10 * BIT_CYC));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovf_clr", 32'(tx_overflow), 32'd0);

    // Reset in the middle of a TX frame
    for (int i = 0; i < 2; i++) begin
      uart_out = 8'hA1 + 8'(i);
      uart_wrreq = 1'b1;
      @(negedge clk);
    end
    uart_wrreq = 1'b0;
    repeat (35) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_empty", 32'(uart_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("rst_mid_no_output", 32'(lows), 32'd0);
    check("rst_mid_rx_empty", 32'(uart_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
